glitch_sequencer: RTL and testbench
===================================

// Module: glitch_sequencer
// PURPOSE
//  Sequences one glitch attempt for the glitcher top level. On arm: assert target
//  reset, release it, await the configured trigger edge, wait a programmable delay,
//  then emit a burst of N pulses with programmable width/gap. glitch_control drives
//  cfg/arm/abort from UART commands; the outputs drive the pins.
// PARAMETERS
//  DELAY_W   32  width of delay, timeout counters (cycles of clk)
//  WIDTH_W   16  width of pulse width, gap, reset-hold counters
//  COUNT_W    8  width of pulse repeat count
// PORTS
//  clk            in   1        system clock (50 MHz)
//  rst            in   1        asynchronous reset, active-high
//  cfg_reset_i    in   WIDTH_W  target reset hold cycles; 0 = skip reset phase
//  cfg_edge_i     in   1        trigger polarity: 0 rising, 1 falling
//  cfg_delay_i    in   DELAY_W  cycles from trigger edge to first pulse
//  cfg_width_i    in   WIDTH_W  pulse high cycles; 0 treated as 1
//  cfg_gap_i      in   WIDTH_W  low cycles between pulses; 0 treated as 1
//  cfg_repeat_i   in   COUNT_W  pulses per attempt; 0 treated as 1
//  cfg_timeout_i  in   DELAY_W  max cycles in WAIT_TRIG; 0 = wait forever
//  arm_i          in   1        start attempt (1-cycle strobe)
//  abort_i        in   1        cancel attempt (1-cycle strobe)
//  trigger_i      in   1        async target trigger pin
//  target_reset_o out  1        target reset, active-high
//  pulse_o        out  1        glitch pulse
//  pulse_en_o     out  1        high from entry to DELAY until burst ends
//  busy_o         out  1        high in any state but IDLE
//  done_o         out  1        1-cycle strobe: burst completed
//  timeout_o      out  1        1-cycle strobe: trigger never arrived
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters and cfg shadow cleared.
//  - All outputs registered. No combinational path from input to output.
//  - arm_i in IDLE latches all cfg_* into shadow regs. cfg changes mid-attempt are
//    ignored. arm_i outside IDLE is ignored.
//  - trigger_i passes a 2-flop synchronizer, then an edge detector on the
//    synchronized signal.
//  - States and transitions:
//    IDLE --arm--> RESET. If cfg_reset == 0, go to WAIT_TRIG instead.
//    RESET: target_reset_o = 1 for exactly cfg_reset cycles -> WAIT_TRIG.
//    WAIT_TRIG: edge detect is live here only. Edges before this state are discarded.
//      On matching edge -> DELAY. If cfg_timeout != 0 and cfg_timeout cycles
//      elapse with no edge -> IDLE with timeout_o strobe.
//    DELAY: count cfg_delay cycles -> PULSE.
//    PULSE: pulse_o = 1 for width cycles. Then:
//      - remaining pulses > 0 -> GAP;
//      - otherwise -> IDLE with done_o strobe.
//    GAP: pulse_o = 0 for gap cycles -> PULSE.
//  - Latency: if trigger_i is first sampled at its new level on clk edge k, pulse_o
//    rises at edge k+3+cfg_delay. With delay 0, that is k+3.
//  - Pulse timing:
//    - each pulse is exactly max(width,1) cycles high;
//    - each gap is exactly max(gap,1) cycles low;
//    - the burst is exactly max(repeat,1) pulses.
//  - busy_o falls in the same cycle done_o/timeout_o pulses. arm_i is accepted in
//    the next cycle.
//  - abort_i in any non-IDLE state:
//    - next cycle is IDLE;
//    - pulse_o, target_reset_o and pulse_en_o drop to 0 that cycle;
//    - no done_o or timeout_o strobe.
//    abort_i wins over a simultaneous arm_i, edge, or counter expiry.
//  - Counters are down-counters that load on state entry. No wrap-around:
//    - full-scale values (e.g. delay 2^DELAY_W-1) are honoured exactly;
//    - the timeout counter saturates.
//  - rst asserted mid-attempt forces IDLE and outputs 0 asynchronously.
// STRUCTURE
//  - glitch_pkg holds:
//    - state enum (IDLE, RESET, WAIT_TRIG, DELAY, PULSE, GAP);
//    - default width localparams;
//    - EDGE_RISE/EDGE_FALL constants.
//    glitch_control shares glitch_pkg.
//  - Sub-module trigger_sync: 2-flop synchronizer plus polarity-selectable edge
//    detector, enable input, 1-cycle edge strobe out. Also usable by glitch_control.
//  - The remainder is one FSM with a shared DELAY_W down-counter (delay, timeout,
//    width, gap, reset) and a COUNT_W pulse counter.
// TESTING
//  1. reset=4, edge=rise, delay=10, width=3, repeat=1, arm, trigger rises edge k:
//     - target_reset_o high 4 cycles;
//     - pulse_o high on edges k+13..k+15;
//     - done_o at k+16.
//  2. repeat=3, width=2, gap=5, delay=0: exactly 3 pulses, each 2 high / 5 low apart.
//     pulse_en_o spans the burst. One done_o strobe.
//  3. timeout=100, no trigger:
//     - timeout_o strobes 100 cycles after WAIT_TRIG entry;
//     - pulse_o never high;
//     - busy_o drops.
//  4. Trigger edge during RESET phase only: ignored, FSM stays in WAIT_TRIG.
//     Then edge=fall, falling edge triggers, rising edge does not.
//  5. abort_i mid-DELAY and mid-PULSE:
//     - outputs 0 and IDLE next cycle;
//     - no done_o;
//     - abort+arm same cycle -> IDLE.
//  6. width=0/gap=0/repeat=0 -> one 1-cycle pulse.
//     cfg changed after arm has no effect. rst mid-PULSE clears pulse_o asynchronously.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and constants for the glitcher datapath: FSM state encoding,
// default counter widths and trigger polarity codes.
package glitch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        WAIT_TRIG,
        DELAY,
        PULSE,
        GAP
    } state_t;

    localparam int DEFAULT_DELAY_W = 32;
    localparam int DEFAULT_WIDTH_W = 16;
    localparam int DEFAULT_COUNT_W = 8;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/trigger_sync.sv
// Two-flop synchronizer for an asynchronous pin followed by a polarity-selectable
// edge detector; emits a 1-cycle strobe only while enabled.
module trigger_sync
    import glitch_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_trig,
    input  logic i_edge_sel,
    input  logic i_en,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_rise;
    logic w_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_trig;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign w_rise = r_sync & ~r_prev;
    assign w_fall = ~r_sync & r_prev;
    assign o_edge = i_en & ((i_edge_sel == EDGE_FALL) ? w_fall : w_rise);

endmodule

// File: rtl/glitch_sequencer.sv
// Sequences one glitch attempt: optional target reset, wait for trigger edge,
// programmable delay, then a burst of pulses with programmable width and gap.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W = DEFAULT_DELAY_W,
    parameter int WIDTH_W = DEFAULT_WIDTH_W,
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH_W-1:0] cfg_reset_i,
    input  logic               cfg_edge_i,
    input  logic [DELAY_W-1:0] cfg_delay_i,
    input  logic [WIDTH_W-1:0] cfg_width_i,
    input  logic [WIDTH_W-1:0] cfg_gap_i,
    input  logic [COUNT_W-1:0] cfg_repeat_i,
    input  logic [DELAY_W-1:0] cfg_timeout_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic               trigger_i,
    output logic               target_reset_o,
    output logic               pulse_o,
    output logic               pulse_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);

    typedef struct packed {
        logic [WIDTH_W-1:0] reset_hold;
        logic               edge_sel;
        logic [DELAY_W-1:0] delay;
        logic [WIDTH_W-1:0] width;
        logic [WIDTH_W-1:0] gap;
        logic [COUNT_W-1:0] repeat_n;
        logic [DELAY_W-1:0] timeout;
    } cfg_t;

    state_t             r_state;
    state_t             w_next;
    cfg_t               r_cfg;
    cfg_t               w_cfg_in;
    cfg_t               w_cfg;
    logic [DELAY_W-1:0] r_cnt;
    logic [DELAY_W-1:0] w_cnt_next;
    logic [COUNT_W-1:0] r_pcnt;
    logic [COUNT_W-1:0] w_pcnt_next;
    logic               w_done_next;
    logic               w_timeout_next;
    logic               w_edge;
    logic               w_accept_arm;

    logic r_target_reset;
    logic r_pulse;
    logic r_pulse_en;
    logic r_busy;
    logic r_done;
    logic r_timeout;

    // Counter preload for a phase of max(cycles,1) cycles: the phase ends when
    // the down-counter is observed at zero.
    function automatic logic [DELAY_W-1:0] span_load(input logic [WIDTH_W-1:0] cycles);
        return (cycles == '0) ? '0 : DELAY_W'(cycles - WIDTH_W'(1));
    endfunction

    function automatic logic [DELAY_W-1:0] timeout_load(input logic [DELAY_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - DELAY_W'(1);
    endfunction

    assign w_cfg_in = '{
        reset_hold: cfg_reset_i,
        edge_sel:   cfg_edge_i,
        delay:      cfg_delay_i,
        width:      cfg_width_i,
        gap:        cfg_gap_i,
        repeat_n:   cfg_repeat_i,
        timeout:    cfg_timeout_i
    };

    // In IDLE the live inputs feed the first-phase counter load; afterwards only
    // the shadow copy is used, so host-side cfg changes cannot disturb an attempt.
    assign w_cfg        = (r_state == IDLE) ? w_cfg_in : r_cfg;
    assign w_accept_arm = (r_state == IDLE) && arm_i && !abort_i;

    trigger_sync u_trigger_sync (
        .clk        (clk),
        .rst        (rst),
        .i_trig     (trigger_i),
        .i_edge_sel (w_cfg.edge_sel),
        .i_en       (r_state == WAIT_TRIG),
        .o_edge     (w_edge)
    );

    // NOTE: every signal driven here gets a default first; any path that left one
    // unassigned would infer a latch.
    always_comb begin
        w_next         = r_state;
        w_cnt_next     = r_cnt;
        w_pcnt_next    = r_pcnt;
        w_done_next    = 1'b0;
        w_timeout_next = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (arm_i) begin
                    w_pcnt_next = (w_cfg.repeat_n == '0) ? '0 : w_cfg.repeat_n - COUNT_W'(1);
                    if (w_cfg.reset_hold == '0) begin
                        w_next     = WAIT_TRIG;
                        w_cnt_next = timeout_load(w_cfg.timeout);
                    end else begin
                        w_next     = RESET;
                        w_cnt_next = span_load(w_cfg.reset_hold);
                    end
                end
            end
            RESET: begin
                if (r_cnt == '0) begin
                    w_next     = WAIT_TRIG;
                    w_cnt_next = timeout_load(w_cfg.timeout);
                end else begin
                    w_cnt_next = r_cnt - DELAY_W'(1);
                end
            end
            WAIT_TRIG: begin
                if (w_edge) begin
                    w_next     = DELAY;
                    w_cnt_next = w_cfg.delay;
                end else if (w_cfg.timeout != '0) begin
                    if (r_cnt == '0) begin
                        w_next         = IDLE;
                        w_timeout_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - DELAY_W'(1);
                    end
                end
            end
            DELAY: begin
                // Occupies delay+1 cycles so pulse_o rises delay cycles after the
                // fixed 3-cycle synchronizer/detector/register latency.
                if (r_cnt == '0) begin
                    w_next     = PULSE;
                    w_cnt_next = span_load(w_cfg.width);
                end else begin
                    w_cnt_next = r_cnt - DELAY_W'(1);
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    if (r_pcnt != '0) begin
                        w_next      = GAP;
                        w_cnt_next  = span_load(w_cfg.gap);
                        w_pcnt_next = r_pcnt - COUNT_W'(1);
                    end else begin
                        w_next      = IDLE;
                        w_done_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - DELAY_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_next     = PULSE;
                    w_cnt_next = span_load(w_cfg.width);
                end else begin
                    w_cnt_next = r_cnt - DELAY_W'(1);
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Abort overrides arm, trigger edges and counter expiry alike.
        if (abort_i) begin
            w_next         = IDLE;
            w_done_next    = 1'b0;
            w_timeout_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_cfg   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_pcnt  <= w_pcnt_next;
            if (w_accept_arm) begin
                r_cfg <= w_cfg_in;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so they change on
    // the same edge as the state and never see an input combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target_reset <= 1'b0;
            r_pulse        <= 1'b0;
            r_pulse_en     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_target_reset <= (w_next == RESET);
            r_pulse        <= (w_next == PULSE);
            r_pulse_en     <= (w_next inside {DELAY, PULSE, GAP});
            r_busy         <= (w_next != IDLE);
            r_done         <= w_done_next;
            r_timeout      <= w_timeout_next;
        end
    end

    assign target_reset_o = r_target_reset;
    assign pulse_o        = r_pulse;
    assign pulse_en_o     = r_pulse_en;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: directed scenarios plus randomized
// attempts, all compared cycle by cycle against an arithmetic timing model.
module tb_glitch_sequencer;
    import glitch_pkg::*;

    localparam int HMAX  = 16384;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_reset_i = '0;
    logic        cfg_edge_i = 1'b0;
    logic [31:0] cfg_delay_i = '0;
    logic [15:0] cfg_width_i = '0;
    logic [15:0] cfg_gap_i = '0;
    logic [7:0]  cfg_repeat_i = '0;
    logic [31:0] cfg_timeout_i = '0;
    logic        arm_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        trigger_i = 1'b0;
    logic        target_reset_o;
    logic        pulse_o;
    logic        pulse_en_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;

    always #5 clk = ~clk;

    glitch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_reset_i    (cfg_reset_i),
        .cfg_edge_i     (cfg_edge_i),
        .cfg_delay_i    (cfg_delay_i),
        .cfg_width_i    (cfg_width_i),
        .cfg_gap_i      (cfg_gap_i),
        .cfg_repeat_i   (cfg_repeat_i),
        .cfg_timeout_i  (cfg_timeout_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .trigger_i      (trigger_i),
        .target_reset_o (target_reset_o),
        .pulse_o        (pulse_o),
        .pulse_en_o     (pulse_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o)
    );

    typedef struct {
        int   a;
        int   rh;
        logic edge_f;
        int   delay;
        int   width;
        int   gap;
        int   rep;
        int   timeout;
        int   k;
        int   abort_at;
    } attempt_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Output history, index = number of rising clock edges seen; bit order
    // {target_reset, pulse, pulse_en, busy, done, timeout}.
    logic [5:0] hist [HMAX];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < HMAX) hist[cyc] <= {target_reset_o, pulse_o, pulse_en_o, busy_o, done_o, timeout_o};
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic attempt_t mk(input int rh, input logic edge_f, input int delay,
                                    input int width, input int gap, input int rep,
                                    input int timeout);
        attempt_t m;
        m.a = 0; m.rh = rh; m.edge_f = edge_f; m.delay = delay; m.width = width;
        m.gap = gap; m.rep = rep; m.timeout = timeout; m.k = -1; m.abort_at = NEVER;
        return m;
    endfunction

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Cycle at which done_o strobes for a triggered attempt.
    function automatic int fin_of(input attempt_t m);
        return m.k + 3 + m.delay + max1(m.rep) * max1(m.width) + (max1(m.rep) - 1) * max1(m.gap);
    endfunction

    // Expected outputs after rising edge c, derived from the timing rules.
    function automatic logic [5:0] expect_at(input attempt_t m, input int c);
        logic tr, p, pe, b, d, to;
        int   e, ps, fin;
        tr = 0; p = 0; pe = 0; b = 0; d = 0; to = 0;
        if (c < m.a || c >= m.abort_at) return 6'b0;
        e  = m.a + m.rh;
        tr = (c < e);
        if (m.k >= 0) begin
            ps  = m.k + 3 + m.delay;
            fin = fin_of(m);
            b   = (c < fin);
            d   = (c == fin);
            pe  = (c >= m.k + 2) && (c < fin);
            for (int i = 0; i < max1(m.rep); i++) begin
                if (c >= ps + i * (max1(m.width) + max1(m.gap)) &&
                    c <  ps + i * (max1(m.width) + max1(m.gap)) + max1(m.width)) p = 1;
            end
        end else if (m.timeout != 0) begin
            b  = (c < e + m.timeout);
            to = (c == e + m.timeout);
        end else begin
            b = 1;
        end
        return {tr, p, pe, b, d, to};
    endfunction

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic prep(input logic lvl);
        @(negedge clk);
        trigger_i = lvl;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_arm(input attempt_t m, output int a);
        @(negedge clk);
        cfg_reset_i   = 16'(m.rh);
        cfg_edge_i    = m.edge_f;
        cfg_delay_i   = 32'(m.delay);
        cfg_width_i   = 16'(m.width);
        cfg_gap_i     = 16'(m.gap);
        cfg_repeat_i  = 8'(m.rep);
        cfg_timeout_i = 32'(m.timeout);
        arm_i         = 1'b1;
        a             = cyc + 1;
        @(negedge clk);
        arm_i         = 1'b0;
        cfg_reset_i   = 16'($urandom);
        cfg_edge_i    = 1'($urandom);
        cfg_delay_i   = $urandom;
        cfg_width_i   = 16'($urandom);
        cfg_gap_i     = 16'($urandom);
        cfg_repeat_i  = 8'($urandom);
        cfg_timeout_i = $urandom_range(1, 3);
    endtask

    // Trigger level change first sampled on rising edge c.
    task automatic drive_trig_at(input int c, input logic lvl);
        wait_to(c - 1);
        trigger_i = lvl;
    endtask

    task automatic drive_abort_at(input int b, input logic with_arm);
        wait_to(b - 1);
        abort_i = 1'b1;
        arm_i   = with_arm;
        @(negedge clk);
        abort_i = 1'b0;
        arm_i   = 1'b0;
    endtask

    task automatic check_trace(input string tag, input attempt_t m, input int last);
        int         nbad;
        int         first;
        logic [5:0] fo, fx;
        nbad = 0; first = -1; fo = '0; fx = '0;
        wait_to(last + 2);
        for (int c = m.a; c <= last; c++) begin
            if (hist[c] !== expect_at(m, c)) begin
                if (first < 0) begin
                    first = c; fo = hist[c]; fx = expect_at(m, c);
                end
                nbad++;
            end
        end
        if (nbad != 0)
            $display("  %s: first diff at cycle %0d (a=%0d) observed %b expected %b [tr,p,pe,busy,done,to]",
                     tag, first, m.a, fo, fx);
        check({tag, " trace diffs"}, nbad, 0);
    endtask

    function automatic int count_rise(input int bitn, input int from, input int to);
        int n;
        n = 0;
        for (int c = from; c <= to; c++) if (hist[c][bitn] && !hist[c-1][bitn]) n++;
        return n;
    endfunction

    initial begin
        attempt_t m, m2;
        int a, e, fin, b, last, mode;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst target_reset_o", target_reset_o, 0);
        check("rst pulse_o", pulse_o, 0);
        check("rst pulse_en_o", pulse_en_o, 0);
        check("rst busy_o", busy_o, 0);
        check("rst done_o", done_o, 0);
        check("rst timeout_o", timeout_o, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle busy_o", busy_o, 0);
        check("idle pulse_o", pulse_o, 0);

        // 1: reset hold 4, delay 10, width 3, single pulse
        m = mk(4, EDGE_RISE, 10, 3, 1, 1, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 4 + 3;
        drive_trig_at(m.k, 1'b1);
        check_trace("t1", m, m.k + 20);
        check("t1 reset hi last", hist[a+3][5], 1);
        check("t1 reset lo after", hist[a+4][5], 0);
        check("t1 pulse k+12", hist[m.k+12][4], 0);
        check("t1 pulse k+13", hist[m.k+13][4], 1);
        check("t1 pulse k+15", hist[m.k+15][4], 1);
        check("t1 pulse k+16", hist[m.k+16][4], 0);
        check("t1 done k+16", hist[m.k+16][1], 1);

        // 2: three pulses, width 2 gap 5, delay 0; re-arm the cycle after done
        m = mk(0, EDGE_RISE, 0, 2, 5, 3, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 2;
        drive_trig_at(m.k, 1'b1);
        fin = fin_of(m);
        wait_to(fin - 1);
        m2 = mk(0, EDGE_RISE, 0, 1, 1, 1, 5);
        do_arm(m2, a); m2.a = a;
        check_trace("t2", m, fin);
        check("t2 pulse count", count_rise(4, m.a, fin + 2), 3);
        check("t2 done count", count_rise(1, m.a, fin + 1), 1);
        check("t2 pulse_en at delay", hist[m.k+2][3], 1);
        check("t2 pulse_en end", hist[fin][3], 0);
        check("t2 rearm busy", hist[fin+1][2], 1);
        check_trace("t2 rearm", m2, m2.a + 8);

        // 3: timeout 100 with no trigger
        m = mk(2, EDGE_RISE, 0, 1, 1, 1, 100);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        e = a + 2;
        check_trace("t3", m, e + 104);
        check("t3 busy before", hist[e+99][2], 1);
        check("t3 timeout strobe", hist[e+100][0], 1);
        check("t3 busy after", hist[e+100][2], 0);
        check("t3 no pulse", count_rise(4, m.a, e + 104), 0);

        // 4a: edge during reset ignored, falling edge in rise mode ignored
        m = mk(8, EDGE_RISE, 1, 1, 1, 1, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        e = a + 8;
        drive_trig_at(a + 2, 1'b1);
        drive_trig_at(e + 20, 1'b0);
        m.k = e + 25;
        drive_trig_at(m.k, 1'b1);
        check_trace("t4a", m, fin_of(m) + 3);
        check("t4a still waiting", hist[e+24][2:1], 2'b10);

        // 4b: falling-edge trigger; rising edge ignored
        m = mk(0, EDGE_FALL, 3, 2, 1, 2, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        drive_trig_at(a + 3, 1'b1);
        m.k = a + 15;
        drive_trig_at(m.k, 1'b0);
        check_trace("t4b", m, fin_of(m) + 3);
        check("t4b pulse_en before fall", hist[m.k+1][3], 0);

        // 5a: abort mid-DELAY
        m = mk(0, EDGE_RISE, 40, 2, 1, 1, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 2;
        drive_trig_at(m.k, 1'b1);
        m.abort_at = m.k + 10;
        drive_abort_at(m.abort_at, 1'b0);
        check_trace("t5a", m, m.abort_at + 50);
        check("t5a pulse_en pre", hist[m.abort_at-1][3], 1);
        check("t5a pulse_en post", hist[m.abort_at][3], 0);
        check("t5a no done", count_rise(1, m.a, m.abort_at + 50), 0);

        // 5b: abort together with arm mid-PULSE
        m = mk(1, EDGE_RISE, 0, 20, 3, 2, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 3;
        drive_trig_at(m.k, 1'b1);
        m.abort_at = m.k + 3 + 5;
        drive_abort_at(m.abort_at, 1'b1);
        check_trace("t5b", m, m.abort_at + 70);
        check("t5b pulse pre", hist[m.abort_at-1][4], 1);
        check("t5b pulse post", hist[m.abort_at][4], 0);
        check("t5b busy post", hist[m.abort_at+1][2], 0);

        // 6: zero width/gap/repeat give one 1-cycle pulse
        m = mk(0, EDGE_RISE, 2, 0, 0, 0, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 4;
        drive_trig_at(m.k, 1'b1);
        check_trace("t6", m, fin_of(m) + 5);
        check("t6 pulse count", count_rise(4, m.a, fin_of(m) + 5), 1);
        check("t6 pulse width", hist[m.k+5][4] && !hist[m.k+6][4], 1);

        // Randomized attempts
        for (int i = 0; i < 14; i++) begin
            m = mk($urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 20),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 0);
            mode = $urandom_range(0, 3);
            if (mode == 0) m.timeout = $urandom_range(1, 30);
            else if ($urandom_range(0, 1) == 1) m.timeout = $urandom_range(40, 1000);
            prep(m.edge_f);
            do_arm(m, a); m.a = a;
            if (mode == 0) begin
                last = m.a + m.rh + m.timeout + 3;
            end else begin
                m.k = m.a + m.rh + 1 + $urandom_range(0, 6);
                drive_trig_at(m.k, ~m.edge_f);
                last = fin_of(m) + 3;
                if ($urandom_range(0, 3) == 0) begin
                    m.abort_at = $urandom_range(m.k, fin_of(m));
                    drive_abort_at(m.abort_at, 1'b0);
                end
            end
            check_trace($sformatf("rand%0d", i), m, last);
        end

        // rst mid-PULSE clears outputs without waiting for a clock edge
        m = mk(0, EDGE_RISE, 0, 50, 1, 1, 0);
        prep(1'b0);
        do_arm(m, a); m.a = a;
        m.k = a + 2;
        drive_trig_at(m.k, 1'b1);
        wait_to(m.k + 3 + 5);
        check("rst-mid pulse before", pulse_o, 1);
        #2 rst = 1'b1;
        #1;
        check("rst-mid pulse_o", pulse_o, 0);
        check("rst-mid pulse_en_o", pulse_en_o, 0);
        check("rst-mid busy_o", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-rst busy_o", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
